// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART byte receiver (and the future uart_tx_byte).
// Contents:
//   uart_rx_state_t : receiver FSM state encoding
//   UART_DATA_BITS  : data bits per frame (8N1)
//   UART_IDLE       : idle (mark) level of the serial line
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE      = 1'b1;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
// Parameters:
//   RESET_VAL : value both flops take during reset (use the input's idle level)
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output (2 cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (even, >= 4)
// Ports:
//   clk       : sole clock, posedge
//   rst_n     : asynchronous active-low reset
//   rx        : raw serial line, asynchronous, idles high
//   out_valid : a received byte is held in the buffer
//   out_ready : consumer accepts the buffered byte
//   out_byte  : buffered byte, stable while out_valid is high
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good frame completed while the buffer was full
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [UART_DATA_BITS-1:0] out_byte,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic [1:0]                warm_q;
  logic                      rx_prev_q;
  logic                      start_edge_q;

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      valid_q, valid_d;
  logic [UART_DATA_BITS-1:0] byte_q, byte_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      load_s;
  logic                      buf_free_s;

  sync_2ff #(
    .RESET_VAL (UART_IDLE)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Start-edge detector. The synchronizer shows its reset value for two cycles
  // after reset, so the previous-level flop is held low until rx_s carries real
  // line data; a line that is low at reset release (mid-frame) cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q       <= 2'b00;
      rx_prev_q    <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      warm_q       <= {warm_q[0], 1'b1};
      rx_prev_q    <= warm_q[1] ? rx_s : 1'b0;
      start_edge_q <= (rx_prev_q == UART_IDLE) && (rx_s != UART_IDLE);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_q) state_d = ST_START;
        else              state_d = ST_IDLE;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          if (rx_s != UART_IDLE) state_d = ST_DATA;
          else                   state_d = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if ((cnt_q == BIT_LAST) && (bit_idx_q == IDX_LAST)) state_d = ST_STOP;
        else                                                state_d = ST_DATA;
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rx_s == UART_IDLE) state_d = ST_IDLE;
          else                   state_d = ST_WAIT_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s == UART_IDLE) state_d = ST_IDLE;
        else                   state_d = ST_WAIT_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The buffer can take a new byte if it is empty or being drained this cycle.
  assign buf_free_s = !valid_q || out_ready;

  // FSM output / datapath logic: counters, shift register, frame outcome.
  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    load_s      = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) cnt_d = {CNT_W{1'b0}};
        else                    cnt_d = cnt_q + 1'b1;
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          // LSB arrives first, so shift right and insert at the MSB.
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) bit_idx_d = 3'd0;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_s == UART_IDLE) begin
            if (buf_free_s) load_s    = 1'b1;
            else            overrun_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
      end
      default: begin
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Output buffer next state: a load wins over a drain in the same cycle.
  always_comb begin
    if (load_s) begin
      valid_d = 1'b1;
      byte_d  = shift_q;
    end else begin
      valid_d = valid_q && !out_ready;
      byte_d  = byte_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= {CNT_W{1'b0}};
      bit_idx_q   <= 3'd0;
      shift_q     <= {UART_DATA_BITS{1'b0}};
      valid_q     <= 1'b0;
      byte_q      <= {UART_DATA_BITS{1'b0}};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign out_byte  = byte_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule : uart_rx_byte

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
// Directed self-checking bench for uart_rx_byte at 16 clocks per bit.
// Inputs are driven on the falling clock edge; a monitor samples 1 time unit
// after each falling edge and logs transfers and flag pulses.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int vld_cnt  = 0;
  int lat;
  int vld_base;
  logic [7:0] rxq[$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: a transfer is valid && ready as it will be seen by the next posedge.
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) rxq.push_back(out_byte);
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (out_valid) vld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int i);
    if (rxq.size() > i) return {24'h0, rxq[i]};
    else                return 32'hDEAD;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx        = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_byte",  {24'h0, out_byte},  32'h0);
    check("rst_ferr",  {31'h0, frame_err}, 32'h0);
    check("rst_ovr",   {31'h0, overrun},   32'h0);
    rst_n = 1'b1;
    idle(10);

    // Single frame with latency measurement from the rx falling edge.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!out_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    idle(20);
    check("single_latency", lat, 32'd156);
    check("single_count",   rxq.size(), 32'd1);
    check("single_byte",    qget(0), 32'hA5);
    check("single_ferr",    fe_cnt, 32'd0);
    check("single_ovr",     ov_cnt, 32'd0);

    // Back-to-back frames with no idle gap.
    rxq.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("b2b_count", rxq.size(), 32'd3);
    check("b2b_byte0", qget(0), 32'h00);
    check("b2b_byte1", qget(1), 32'hFF);
    check("b2b_byte2", qget(2), 32'h3C);
    check("b2b_flags", fe_cnt + ov_cnt, 32'd0);

    // Glitch: 3 low cycles must be rejected at the start-bit midpoint.
    rxq.delete();
    vld_base = vld_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(400);
    check("glitch_valid", vld_cnt - vld_base, 32'd0);
    check("glitch_flags", fe_cnt + ov_cnt, 32'd0);

    // Framing error followed by a held-low line, then a good frame.
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    idle(20);
    check("ferr_pulse", fe_cnt, 32'd1);
    check("ferr_none",  rxq.size(), 32'd0);
    send_frame(8'h12, 1'b1);
    idle(20);
    check("ferr_after_count", rxq.size(), 32'd1);
    check("ferr_after_byte",  qget(0), 32'h12);
    check("ferr_ovr",         ov_cnt, 32'd0);

    // Overrun: buffer held full, second frame dropped.
    rxq.delete();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("ovr_valid_held", {31'h0, out_valid}, 32'h1);
    check("ovr_byte_held",  {24'h0, out_byte},  32'h11);
    check("ovr_pulse",      ov_cnt, 32'd1);
    check("ovr_no_xfer",    rxq.size(), 32'd0);
    out_ready = 1'b1;
    idle(5);
    check("ovr_drain_count", rxq.size(), 32'd1);
    check("ovr_drain_byte",  qget(0), 32'h11);
    check("ovr_drain_valid", {31'h0, out_valid}, 32'h0);
    check("ovr_ferr",        fe_cnt, 32'd1);

    // Reset asserted for 2 cycles during data bit 4 of 0x81.
    rxq.delete();
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (CPB * 5 + 6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_byte",  {24'h0, out_byte},  32'h0);
        check("midrst_flags", {30'h0, frame_err, overrun}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(20);
    check("midrst_no81", rxq.size(), 32'd0);
    send_frame(8'h7E, 1'b1);
    idle(20);
    check("midrst_count", rxq.size(), 32'd1);
    check("midrst_byte7e", qget(0), 32'h7E);
    check("midrst_ferr", fe_cnt, 32'd1);
    check("midrst_ovr",  ov_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_byte

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receiver feeding the convolutional encoder's byte input. It oversamples an asynchronous 8N1 serial line (8 data bits, no parity, 1 stop bit), reassembles each frame LSB-first and presents each byte on a valid/ready stream that connects directly to `uart_conv_encoder` `in_valid`/`in_ready`/`in_byte`. A one-entry output buffer absorbs encoder back-pressure. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be an even number ≥ 4.
- `clk`  in  1  sole clock. All logic is posedge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock domain; reset is asynchronous and active-low.
- `rx`  in  1  raw serial line, asynchronous to `clk`. The line idles high.
- `out_valid`  out  1  a byte is held in the buffer.
- `out_ready`  in  1  consumer accepts the byte.
- `out_byte`  out  8  received byte. Stable while `out_valid` is high.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a frame completed while the buffer was full.

## Operation
- **Input synchronizer.** `rx` passes through 2 flops to give `rx_s`; both flops reset to 1. A start edge is the cycle in which `rx_s`=0 and its previous value was 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE.** On a start edge, go to START and load the bit counter with 0.
- **START.** At count `CLKS_PER_BIT/2-1`, sample `rx_s`.
  - Sample is 0: go to DATA and reset the counter.
  - Sample is 1 (glitch): return to IDLE with no flags.
- **DATA.** Every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
- **STOP.** After `CLKS_PER_BIT` cycles, sample `rx_s`.
  - Sample is 1: the frame is good. If the buffer is empty, load it and set `out_valid`. If the buffer is full, drop the new byte, pulse `overrun` and keep the buffered byte. Go to IDLE.
  - Sample is 0: pulse `frame_err`, discard the byte and go to WAIT_IDLE.
- **WAIT_IDLE.** Stay until `rx_s`=1, then go to IDLE. A break condition therefore never produces spurious frames.
- **Output handshake.** A transfer occurs when `out_valid && out_ready` is high on a clock edge. `out_valid` clears the next cycle unless a new byte loads in the same cycle.
- **Simultaneous load and consume.** If the buffer is drained (transfer) in the same cycle a good STOP completes, the new byte loads, `out_valid` stays high and no overrun occurs.
- **Widths.** The counter is `$clog2(CLKS_PER_BIT)` bits wide; the bit index is 3 bits. Neither wraps except on the defined reload.

## Timing
- **Reset values.** `out_valid`=0, `out_byte`=8'h00, `frame_err`=0, `overrun`=0. FSM in IDLE, synchronizer flops =1.
- **Reset mid-frame.** The partial frame is abandoned with no flags. After release, the next start edge is received normally.
- **Sample points.** Let H=`CLKS_PER_BIT/2` and let cycle 0 be the start-edge cycle.
  - Start bit sampled at cycle H.
  - Data bit i sampled at cycle H+(i+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at cycle H+9·`CLKS_PER_BIT`.
- **Output latency.** `out_valid` (or `frame_err`/`overrun`) rises the cycle after the stop sample.
- **End-to-end latency.** From the falling edge on the `rx` pin to `out_valid` is 2 (synchronizer) + 1 (edge) + H+9·`CLKS_PER_BIT` + 1 cycles. With the default this is 156 cycles.
- **Back-to-back frames.** A start edge is accepted the cycle after the stop sample, so frames with a single stop bit are received with no loss.
- **Byte stability.** `out_byte` changes only on a buffer load.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`.
  - `UART_DATA_BITS`=8.
  - Idle line level `UART_IDLE`=1'b1.
  - The same package will serve the future `uart_tx_byte`.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with a reset-value parameter, reused for other asynchronous inputs.
- Everything else is inline in `uart_rx_byte`. The target size is about 150–200 lines.

## Test plan
- **Single frame.** Drive `rx` with one 8N1 frame of 0xA5 at 16 clocks/bit, with `out_ready`=1. Required: exactly one transfer, `out_byte`=0xA5, first `out_valid` at 156 cycles after the falling edge, no flags.
- **Back-to-back frames.** Send frames 0x00, 0xFF, 0x3C with no idle gap, `out_ready`=1. Required: three transfers in that order, no flags.
- **Glitch rejection.** Drive `rx` low for 3 cycles, then idle for 400 cycles. Required: no `out_valid`, `frame_err` or `overrun`.
- **Framing error.** Send 0x55 with the stop bit forced to 0, hold the line low for 50 cycles, then send 0x12. Required: one `frame_err` pulse, no byte for 0x55, then 0x12 received.
- **Overrun.** Hold `out_ready`=0 and send 0x11 then 0x22. Required: `out_valid` held with 0x11, one `overrun` pulse at the second stop sample. After raising `out_ready`, only 0x11 transfers.
- **Reset mid-frame.** Assert `rst_n`=0 for 2 cycles during data bit 4 of 0x81, then send 0x7E. Required: outputs at their reset values during reset, 0x81 never emitted, 0x7E received correctly.
